// File: rtl/xpb_pkg.sv
// Shared defaults and state encodings for the modular-square xpb lookup tables.
package xpb_pkg;

  localparam int XPB_IDX_BITS  = 5;
  localparam int XPB_WORD_BITS = 1024;
  localparam int XPB_NUM_CH    = 1;

  localparam logic [1:0] XPB_ST_IDLE  = 2'd0;
  localparam logic [1:0] XPB_ST_FILL  = 2'd1;
  localparam logic [1:0] XPB_ST_READY = 2'd2;

endpackage

// File: rtl/xpb_mod_add.sv
// Modular add for operands already reduced below m: one wide add, one conditional subtract.
module xpb_mod_add
  import xpb_pkg::*;
#(
  parameter int WORD_BITS = XPB_WORD_BITS
) (
  input  logic [WORD_BITS-1:0] a,
  input  logic [WORD_BITS-1:0] b,
  input  logic [WORD_BITS-1:0] m,
  output logic [WORD_BITS-1:0] y
);

  logic [WORD_BITS:0] sum;

  // The extra sum bit keeps a+b exact when m sits close to 2^WORD_BITS.
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    y   = (sum >= {1'b0, m}) ? WORD_BITS'(sum - {1'b0, m}) : sum[WORD_BITS-1:0];
  end

endmodule

// File: rtl/xpb_table_gen.sv
// Builds entry[j] = (j*B) mod M one entry per cycle, then serves NUM_CH parallel lookups.
module xpb_table_gen
  import xpb_pkg::*;
#(
  parameter int IDX_BITS  = XPB_IDX_BITS,
  parameter int WORD_BITS = XPB_WORD_BITS,
  parameter int NUM_CH    = XPB_NUM_CH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_start,
  input  logic [WORD_BITS-1:0]          cfg_base,
  input  logic [WORD_BITS-1:0]          cfg_mod,
  output logic                          cfg_err,
  output logic                          ready,
  input  logic [NUM_CH-1:0]             lk_valid,
  input  logic [NUM_CH*IDX_BITS-1:0]    lk_idx,
  output logic [NUM_CH-1:0]             rd_valid,
  output logic [NUM_CH*WORD_BITS-1:0]   rd_data
);

  localparam int DEPTH = 1 << IDX_BITS;

  logic [1:0]           state;
  logic [IDX_BITS-1:0]  count;
  logic [WORD_BITS-1:0] acc;
  logic [WORD_BITS-1:0] acc_next;
  logic [WORD_BITS-1:0] b_reg;
  logic [WORD_BITS-1:0] m_reg;
  logic [WORD_BITS-1:0] table_mem [DEPTH];
  logic                 cfg_open;
  logic                 start_ok;
  logic                 start_bad;

  assign ready     = (state == XPB_ST_READY);
  assign cfg_open  = (state != XPB_ST_FILL);
  assign start_ok  = cfg_start && cfg_open && (cfg_base < cfg_mod);
  assign start_bad = cfg_start && cfg_open && !(cfg_base < cfg_mod);

  xpb_mod_add #(.WORD_BITS(WORD_BITS)) u_mod_add (
    .a (acc),
    .b (b_reg),
    .m (m_reg),
    .y (acc_next)
  );

  // Build sequencer: count walks 1..DEPTH-1 and wraps back to 0 on entry to READY.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= XPB_ST_IDLE;
      count   <= '0;
      acc     <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= start_bad;
      if (state == XPB_ST_FILL) begin
        acc   <= acc_next;
        count <= count + 1'b1;
        if (&count) state <= XPB_ST_READY;
      end else if (start_ok) begin
        acc   <= '0;
        count <= IDX_BITS'(1);
        state <= XPB_ST_FILL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start_ok) begin
      b_reg        <= cfg_base;
      m_reg        <= cfg_mod;
      table_mem[0] <= '0;
    end else if (state == XPB_ST_FILL) begin
      table_mem[count] <= acc_next;
    end
  end

  // Lookup stage: one registered read per channel, old table still visible on a rebuild edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        rd_valid[c] <= lk_valid[c] & ready;
        rd_data[c*WORD_BITS +: WORD_BITS] <= (lk_valid[c] & ready)
          ? table_mem[lk_idx[c*IDX_BITS +: IDX_BITS]] : '0;
      end
    end
  end

endmodule

// File: tb/tb_xpb_table_gen.sv
// Directed and randomized checks of xpb_table_gen against a (j*B) mod M reference.
module tb_xpb_table_gen;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Small two-channel instance
  logic        s_start;
  logic [15:0] s_base, s_mod;
  logic        s_err, s_ready;
  logic [1:0]  s_lkv, s_rdv;
  logic [5:0]  s_lki;
  logic [31:0] s_rdd;

  // Default-parameter instance
  logic          d_start;
  logic [1023:0] d_base, d_mod;
  logic          d_err, d_ready;
  logic [0:0]    d_lkv, d_rdv;
  logic [4:0]    d_lki;
  logic [1023:0] d_rdd;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] cur_b = 16'd0;
  logic [15:0] cur_m = 16'd1;
  logic [1023:0] dm, db, rw;

  xpb_table_gen #(.IDX_BITS(3), .WORD_BITS(16), .NUM_CH(2)) dut_s (
    .clk(clk), .reset(reset), .cfg_start(s_start), .cfg_base(s_base), .cfg_mod(s_mod),
    .cfg_err(s_err), .ready(s_ready), .lk_valid(s_lkv), .lk_idx(s_lki),
    .rd_valid(s_rdv), .rd_data(s_rdd)
  );

  xpb_table_gen dut_d (
    .clk(clk), .reset(reset), .cfg_start(d_start), .cfg_base(d_base), .cfg_mod(d_mod),
    .cfg_err(d_err), .ready(d_ready), .lk_valid(d_lkv), .lk_idx(d_lki),
    .rd_valid(d_rdv), .rd_data(d_rdd)
  );

  function automatic logic [15:0] mdl_s(int j, logic [15:0] b, logic [15:0] m);
    logic [31:0] p;
    p = 32'(j) * {16'd0, b};
    return 16'(p % {16'd0, m});
  endfunction

  function automatic logic [1023:0] mdl_d(int j, logic [1023:0] b, logic [1023:0] m);
    logic [1039:0] p;
    p = 1040'(j) * {16'd0, b};
    return 1024'(p % {16'd0, m});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic chkw(string tag, logic [1023:0] obs, logic [1023:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=%0h..%0h expected=%0h..%0h", tag,
             obs[1023:960], obs[255:0], want[1023:960], want[255:0]);
    end
  endtask

  task automatic s_read(int i0, int i1);
    s_lkv = 2'b11;
    s_lki = {3'(i1), 3'(i0)};
    step();
    s_lkv = 2'b00;
    chk("s_rdv", 32'(s_rdv), 32'(3));
    chk("s_rd_ch0", 32'(s_rdd[15:0]), 32'(mdl_s(i0, cur_b, cur_m)));
    chk("s_rd_ch1", 32'(s_rdd[31:16]), 32'(mdl_s(i1, cur_b, cur_m)));
  endtask

  task automatic s_build(logic [15:0] b, logic [15:0] m, bit noisy, bit conc);
    s_start = 1'b1; s_base = b; s_mod = m;
    if (conc) begin s_lkv = 2'b01; s_lki = 6'd2; end
    step();
    s_start = 1'b0; s_lkv = 2'b00;
    chk("s_ready_start_edge", 32'(s_ready), 32'(0));
    if (conc) begin
      chk("s_old_table_rdv", 32'(s_rdv), 32'(1));
      chk("s_old_table_rd0", 32'(s_rdd[15:0]), 32'(mdl_s(2, cur_b, cur_m)));
    end
    cur_b = b; cur_m = m;
    for (int k = 1; k <= 7; k++) begin
      if (noisy) begin
        s_lkv   = 2'b11;
        s_lki   = 6'($urandom);
        s_start = (k == 3) || (k == 5);
        s_base  = (k == 3) ? 16'd20 : 16'd1;
        s_mod   = (k == 3) ? 16'd13 : 16'd2;
      end
      step();
      s_start = 1'b0; s_lkv = 2'b00;
      chk("s_ready_fill", 32'(s_ready), 32'(k == 7));
      if (noisy) begin
        chk("s_err_in_fill", 32'(s_err), 32'(0));
        chk("s_rdv_in_fill", 32'(s_rdv), 32'(0));
      end
    end
  endtask

  task automatic d_build(logic [1023:0] b, logic [1023:0] m);
    d_start = 1'b1; d_base = b; d_mod = m;
    step();
    d_start = 1'b0;
    chk("d_ready_start_edge", 32'(d_ready), 32'(0));
    for (int k = 1; k <= 31; k++) begin
      step();
      chk("d_ready_fill", 32'(d_ready), 32'(k == 31));
    end
  endtask

  initial begin
    reset = 1'b1;
    s_start = 1'b0; s_base = '0; s_mod = '0; s_lkv = '0; s_lki = '0;
    d_start = 1'b0; d_base = '0; d_mod = '0; d_lkv = '0; d_lki = '0;
    step(); step();
    chk("rst_ready", 32'(s_ready), 32'(0));
    chk("rst_cfg_err", 32'(s_err), 32'(0));
    chk("rst_rd_valid", 32'(s_rdv), 32'(0));
    chk("rst_rd_data", s_rdd, 32'(0));
    chk("rst_d_ready", 32'(d_ready), 32'(0));
    reset = 1'b0;
    step();

    // Rejected start in IDLE: B == M
    s_start = 1'b1; s_base = 16'd13; s_mod = 16'd13;
    step();
    s_start = 1'b0;
    chk("bad_idle_err", 32'(s_err), 32'(1));
    chk("bad_idle_ready", 32'(s_ready), 32'(0));
    step();
    chk("bad_idle_err_once", 32'(s_err), 32'(0));
    chk("bad_idle_ready2", 32'(s_ready), 32'(0));
    s_lkv = 2'b11; s_lki = 6'o31;
    step();
    s_lkv = 2'b00;
    chk("idle_rdv", 32'(s_rdv), 32'(0));
    chk("idle_rdd", s_rdd, 32'(0));

    // B=5, M=13 build, read every entry on both channels
    s_build(16'd5, 16'd13, 1'b0, 1'b0);
    for (int j = 0; j < 8; j++) s_read(j, 7 - j);
    s_read(3, 3);
    s_read(7, 1);
    s_lkv = 2'b10; s_lki = {3'd6, 3'd1};
    step();
    s_lkv = 2'b00;
    chk("single_ch_rdv", 32'(s_rdv), 32'(2));
    chk("single_ch_rd0", 32'(s_rdd[15:0]), 32'(0));
    chk("single_ch_rd1", 32'(s_rdd[31:16]), 32'(mdl_s(6, cur_b, cur_m)));
    step();
    chk("no_lookup_rdv", 32'(s_rdv), 32'(0));

    // Rejected start in READY keeps serving the table
    s_start = 1'b1; s_base = 16'd20; s_mod = 16'd13;
    s_lkv = 2'b01; s_lki = 6'd4;
    step();
    s_start = 1'b0; s_lkv = 2'b00;
    chk("bad_ready_err", 32'(s_err), 32'(1));
    chk("bad_ready_ready", 32'(s_ready), 32'(1));
    chk("bad_ready_rdd", 32'(s_rdd[15:0]), 32'(mdl_s(4, cur_b, cur_m)));
    step();
    chk("bad_ready_err_once", 32'(s_err), 32'(0));
    s_read(5, 6);

    // Rebuild from READY with a same-cycle lookup, starts ignored during FILL
    s_build(16'd3, 16'd11, 1'b1, 1'b1);
    for (int j = 0; j < 8; j++) s_read(j, (j + 3) % 8);

    // Reset in the middle of a build
    s_start = 1'b1; s_base = 16'd7; s_mod = 16'd17;
    step();
    s_start = 1'b0;
    step(); step(); step();
    reset = 1'b1; s_lkv = 2'b11; s_lki = 6'd0;
    step();
    reset = 1'b0;
    chk("abort_ready", 32'(s_ready), 32'(0));
    chk("abort_rdv", 32'(s_rdv), 32'(0));
    chk("abort_rdd", s_rdd, 32'(0));
    step();
    s_lkv = 2'b00;
    chk("abort_lookup_rdv", 32'(s_rdv), 32'(0));
    chk("abort_ready2", 32'(s_ready), 32'(0));
    s_build(16'd7, 16'd17, 1'b1, 1'b0);
    s_read(3, 5);
    s_read(7, 0);

    // Randomized builds and lookups on the small instance
    for (int r = 0; r < 6; r++) begin
      logic [15:0] m, b;
      m = 16'($urandom_range(65535, 1));
      b = 16'($urandom_range(32'(m) - 1, 0));
      if (r % 2 == 1) begin
        s_start = 1'b1; s_mod = m;
        s_base = (r == 3) ? 16'hFFFF : m;
        step();
        s_start = 1'b0;
        chk("rand_bad_err", 32'(s_err), 32'(1));
        chk("rand_bad_ready", 32'(s_ready), 32'(1));
        s_read(int'($urandom_range(7, 0)), int'($urandom_range(7, 0)));
      end
      s_build(b, m, r[0], r[1]);
      for (int i = 0; i < 6; i++)
        s_read(int'($urandom_range(7, 0)), int'($urandom_range(7, 0)));
    end

    // Default widths: M just below 2^1024, B = M-1
    dm = {1024{1'b1}} - 1024'($urandom_range(1000, 0));
    db = dm - 1024'(1);
    d_build(db, dm);
    for (int j = 0; j < 32; j++) begin
      d_lkv = 1'b1; d_lki = 5'(j);
      step();
      d_lkv = 1'b0;
      chk("d_rdv", 32'(d_rdv), 32'(1));
      chkw("d_entry", d_rdd, mdl_d(j, db, dm));
      if (j >= 1) chkw("d_m_minus_j", d_rdd, dm - 1024'(j));
    end

    // Default widths: random operands, rebuilt from READY
    for (int w = 0; w < 32; w++) begin
      dm[w*32 +: 32] = $urandom;
      rw[w*32 +: 32] = $urandom;
    end
    dm[1023] = 1'b1;
    db = rw % dm;
    d_build(db, dm);
    for (int i = 0; i < 8; i++) begin
      int j;
      j = int'($urandom_range(31, 0));
      d_lkv = 1'b1; d_lki = 5'(j);
      step();
      d_lkv = 1'b0;
      chk("d_rand_rdv", 32'(d_rdv), 32'(1));
      chkw("d_rand_entry", d_rdd, mdl_d(j, db, dm));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
